lut_mapper: RTL
===============

LUT_MAPPER -- requirements
Module: lut_mapper

Interface
REQ-001 Parameter DataWidth, default 8, bits per pixel sample.
REQ-002 Parameter NumChannels, default 4, pixel samples per stream beat.
REQ-003 Parameter numIntLevels, default 2**DataWidth, entries per lookup table.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_resetn  in  1  reset, asynchronous, active-low.
REQ-006 i_enable  in  1  mapper enable; low blocks acceptance of new beats.
REQ-007 i_tbl_wr_en  in  1  table write strobe, shadow bank.
REQ-008 i_tbl_wr_addr  in  DataWidth  table entry index.
REQ-009 i_tbl_wr_data  in  DataWidth  table entry value.
REQ-010 i_tbl_swap  in  1  one-cycle request to make the shadow bank active.
REQ-011 o_tbl_busy  out  1  swap pending; table writes ignored.
REQ-012 o_active_bank  out  1  index of bank used for lookup.
REQ-013 i_pixel_data  in  NumChannels*DataWidth  input samples; channel k at bits [k*DataWidth +: DataWidth].
REQ-014 i_pixel_valid, i_pixel_last  in  1 each  input beat valid, end-of-frame marker.
REQ-015 o_pixel_ready  out  1  input beat accepted when valid and ready both high.
REQ-016 o_pixel_data  out  NumChannels*DataWidth  mapped samples, same channel packing.
REQ-017 o_pixel_valid, o_pixel_last  out  1 each  output beat valid, end-of-frame marker.
REQ-018 i_out_ready  in  1  downstream ready.

Function
REQ-019 Block SHALL hold two banks of numIntLevels x DataWidth entries; one active, one shadow.
REQ-020 Output channel k SHALL equal active_bank[input channel k], all channels looked up in parallel, one shared active bank per beat.
REQ-021 Latency SHALL be exactly 1 cycle: beat accepted at edge N appears on outputs after edge N, with its last flag.
REQ-022 o_pixel_ready SHALL equal i_enable AND (NOT o_pixel_valid OR i_out_ready), combinationally.
REQ-023 Output register SHALL hold data/valid/last stable while o_pixel_valid=1 and i_out_ready=0.
REQ-024 When output consumed and no beat accepted in the same cycle, o_pixel_valid SHALL drop to 0 on that edge.
REQ-025 Simultaneous consume and accept SHALL replace the output beat with no bubble (full throughput, 1 beat/cycle).
REQ-026 i_enable low SHALL not drop or alter a beat already in the output register.
REQ-027 Write with i_tbl_wr_en=1 and o_tbl_busy=0 SHALL update shadow[i_tbl_wr_addr] at the edge; writes while o_tbl_busy=1 SHALL be ignored.
REQ-028 in_frame flag SHALL set on acceptance of a beat with last=0 and clear on acceptance of a beat with last=1.
REQ-029 i_tbl_swap=1 SHALL set pending (o_tbl_busy=1) from the next cycle; requests while pending are absorbed.
REQ-030 Swap SHALL execute (toggle o_active_bank, clear pending) at an edge where pending=1 and either a beat with last=1 is accepted, or in_frame=0 and no beat is accepted.
REQ-031 Beat accepted on the swap edge SHALL use the pre-swap bank; swap never occurs mid-frame.
REQ-032 i_tbl_swap arriving on a cycle where pending=0 SHALL NOT swap on that same edge; earliest swap is the following edge.
REQ-033 Table write addresses SHALL cover 0..numIntLevels-1 with no wrap or overflow logic needed.

Reset
REQ-034 i_resetn low SHALL immediately clear o_pixel_valid, o_pixel_last, o_pixel_data, o_active_bank, pending, in_frame to 0.
REQ-035 Table contents SHALL NOT be reset; software loads both banks before use.
REQ-036 Reset mid-frame SHALL discard the held output beat; first beat after release starts a new frame.

Verification
REQ-037 Load shadow bank 0 with identity, swap idle, load bank with f(x)=255-x; send beat {0x00,0x10,0x80,0xFF} -> output {0x00,0x10,0x80,0xFF} one cycle later.
REQ-038 Swap request mid-frame of 4 beats -> o_tbl_busy=1, beats 2-4 identity-mapped, o_active_bank toggles at the edge accepting beat 4; next frame outputs {0xFF,0xEF,0x7F,0x00}.
REQ-039 Hold i_out_ready=0 for 3 cycles with valid input -> o_pixel_ready=0, output beat stable, no beat lost or duplicated after release.
REQ-040 Write to address 0x10 while o_tbl_busy=1 -> entry unchanged after swap completes.
REQ-041 Continuous valid with i_out_ready=1 for 16 beats -> 16 outputs on 16 consecutive cycles, last on beat 16 only.
REQ-042 Assert i_resetn low with o_pixel_valid=1 and pending=1 -> outputs 0, o_tbl_busy=0, o_active_bank=0 before next clock edge.

Source files
------------

// File: rtl/lut_mapper.sv
// lut_mapper: per-channel pixel lookup through a double-buffered table.
// Table swaps are deferred to a frame boundary so no frame mixes two banks.
`default_nettype none

module lut_mapper #(
  parameter int DataWidth    = 8,
  parameter int NumChannels  = 4,
  parameter int numIntLevels = 2**DataWidth
) (
  input  logic                             i_clk,
  input  logic                             i_resetn,
  input  logic                             i_enable,
  input  logic                             i_tbl_wr_en,
  input  logic [DataWidth-1:0]             i_tbl_wr_addr,
  input  logic [DataWidth-1:0]             i_tbl_wr_data,
  input  logic                             i_tbl_swap,
  output logic                             o_tbl_busy,
  output logic                             o_active_bank,
  input  logic [NumChannels*DataWidth-1:0] i_pixel_data,
  input  logic                             i_pixel_valid,
  input  logic                             i_pixel_last,
  output logic                             o_pixel_ready,
  output logic [NumChannels*DataWidth-1:0] o_pixel_data,
  output logic                             o_pixel_valid,
  output logic                             o_pixel_last,
  input  logic                             i_out_ready
);

  logic [DataWidth-1:0]             mem_q [2][numIntLevels];
  logic [NumChannels*DataWidth-1:0] data_q, data_d, lookup;
  logic                             valid_q, valid_d;
  logic                             last_q, last_d;
  logic                             active_q, active_d;
  logic                             pending_q, pending_d;
  logic                             in_frame_q, in_frame_d;
  logic                             accept;
  logic                             swap_now;

  assign o_pixel_ready = i_enable && (!valid_q || i_out_ready);
  assign o_pixel_data  = data_q;
  assign o_pixel_valid = valid_q;
  assign o_pixel_last  = last_q;
  assign o_tbl_busy    = pending_q;
  assign o_active_bank = active_q;

  // Table storage is deliberately left out of reset; software loads it.
  always_ff @(posedge i_clk) begin
    if (i_tbl_wr_en && !pending_q) begin
      mem_q[~active_q][i_tbl_wr_addr] <= i_tbl_wr_data;
    end
  end

  always_comb begin
    lookup = '0;
    for (int k = 0; k < NumChannels; k++) begin
      lookup[k*DataWidth +: DataWidth] = mem_q[active_q][i_pixel_data[k*DataWidth +: DataWidth]];
    end
  end

  always_comb begin
    accept     = i_pixel_valid && o_pixel_ready;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    in_frame_d = in_frame_q;
    if (accept) begin
      data_d     = lookup;
      valid_d    = 1'b1;
      last_d     = i_pixel_last;
      in_frame_d = !i_pixel_last;
    end else if (i_out_ready) begin
      valid_d = 1'b0;
    end
    // Swap only between frames: on the closing beat, or while idle outside a frame.
    swap_now  = pending_q && ((accept && i_pixel_last) || (!in_frame_q && !accept));
    active_d  = active_q ^ swap_now;
    pending_d = swap_now ? 1'b0 : (pending_q || i_tbl_swap);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      active_q   <= 1'b0;
      pending_q  <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      in_frame_q <= in_frame_d;
    end
  end

endmodule

`default_nettype wire
